// File: rtl/mp2_mem_responder_pkg.sv
// Shared types for the mp2 memory responder: CPU word type and FSM/counter types.

package rv32i_types;

    typedef logic [31:0] rv32i_word;

endpackage : rv32i_types

package mem_resp_types;

    // Latency counter width; LATENCY up to 15 fits.
    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = 4'd0;
    localparam cnt_t CNT_ONE  = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

endpackage : mem_resp_types

// File: rtl/mp2_mem_responder_array.sv
// Word-organised backing store with byte write enables and a registered read port.
// The read register can also be cleared so out-of-range reads return zero.

module mp2_mem_array
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [3:0]            be,
    input  rv32i_word             wdata,
    input  logic                  re,
    input  logic                  clr,
    output rv32i_word             rdata
);

    rv32i_word mem_q [2**ADDR_WIDTH];
    rv32i_word rdata_d;
    rv32i_word rdata_q;

    // Byte-lane write into the storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem_q[addr][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    // Next read-register value: load on read, zero on clear, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end else if (clr) begin
            rdata_d = 32'd0;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register, cleared by reset and held between accesses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : mp2_mem_array

// File: rtl/mp2_mem_responder.sv
// Memory-side responder for the mp2 CPU port: latches a request, waits a
// programmable number of edges, then performs the access and pulses mem_resp.

module mp2_mem_responder
    import rv32i_types::*;
    import mem_resp_types::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  rv32i_word   mem_wdata,
    output logic        mem_resp,
    output rv32i_word   mem_rdata,
    output logic        mem_err
);

    mem_resp_state_t state_d, state_q;
    cnt_t            cnt_d, cnt_q;
    logic [31:0]     addr_d, addr_q;
    rv32i_word       wdata_d, wdata_q;
    logic [3:0]      be_d, be_q;
    logic            rd_d, rd_q;
    logic            wr_d, wr_q;
    logic            resp_d, resp_q;
    logic            err_d, err_q;

    logic                  req_s;
    logic [31:0]           off_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic                  ram_clr_s;

    assign req_s      = mem_read | mem_write;
    // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
    assign off_s      = addr_q - BASE_ADDR;
    assign in_range_s = ((off_s >> (ADDR_WIDTH + 2)) == 32'd0);
    assign idx_s      = off_s[ADDR_WIDTH+1:2];

    // Next-state, latch and access-strobe logic for the request FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        resp_d    = 1'b0;
        err_d     = 1'b0;
        ram_we_s  = 1'b0;
        ram_re_s  = 1'b0;
        ram_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_d  = mem_address;
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    cnt_d   = cnt_t'(LATENCY - 1);
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    if (rd_q && wr_q) begin
                        err_d = 1'b1;
                    end else if (!in_range_s) begin
                        err_d     = 1'b1;
                        ram_clr_s = rd_q;
                    end else begin
                        ram_re_s = rd_q;
                        ram_we_s = wr_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, latched request and registered response flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    mp2_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .addr  (idx_s),
        .we    (ram_we_s),
        .be    (be_q),
        .wdata (wdata_q),
        .re    (ram_re_s),
        .clr   (ram_clr_s),
        .rdata (mem_rdata)
    );

    assign mem_resp = resp_q;
    assign mem_err  = err_q;

endmodule : mp2_mem_responder
